// File: rtl/vn_pair_encoder_if.sv
// Bit-stream valid/ready handshake into the pair encoder.
// The master offers in_bit/in_valid and the encoder returns in_ready.
interface vn_pair_encoder_if;
    logic in_bit;
    logic in_valid;
    logic in_ready;

    modport master (
        output in_bit,
        output in_valid,
        input  in_ready
    );

    modport slave (
        input  in_bit,
        input  in_valid,
        output in_ready
    );
endinterface

// File: rtl/vn_pair_encoder.sv
// Von Neumann pair encoder: a FIFO feeds bits out as (b, ~b) pairs.
// When no data is sent, it emits equal filler pairs with alternating polarity.
module vn_pair_encoder #(
    parameter int DEPTH = 8,
    parameter int CNT_W = 16
) (
    input  logic                       clk,
    input  logic                       rstn,
    vn_pair_encoder_if.slave           bus,
    input  logic                       tx_en,
    input  logic                       cnt_clr,
    output logic                       out_bit,
    output logic                       out_phase,
    output logic                       out_data,
    output logic [$clog2(DEPTH+1)-1:0] level,
    output logic [CNT_W-1:0]           data_pairs,
    output logic [CNT_W-1:0]           fill_pairs
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int LW = $clog2(DEPTH + 1);

    typedef enum logic {
        SECOND   = 1'b0,
        BOUNDARY = 1'b1
    } phase_t;

    phase_t          state;
    logic            mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic            second_bit;
    logic            fpol;
    logic            push;
    logic            pop;
    logic            head;

    assign bus.in_ready = (level != LW'(DEPTH));
    assign push         = bus.in_valid && bus.in_ready;
    assign pop          = (state == BOUNDARY) && tx_en && (level != '0);
    assign head         = mem[rd_ptr];
    assign out_phase    = (state == BOUNDARY);

    // FIFO storage; contents need no reset because level guards every read
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= bus.in_bit;
        end
    end

    // FIFO pointers and occupancy; level moves by push minus pop
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            level <= level + LW'(push) - LW'(pop);
        end
    end

    // Pair FSM: boundary edges start a data or filler pair, second edges finish it
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state      <= BOUNDARY;
            out_bit    <= 1'b0;
            out_data   <= 1'b0;
            second_bit <= 1'b0;
            fpol       <= 1'b0;
            data_pairs <= '0;
            fill_pairs <= '0;
        end else begin
            unique case (state)
                BOUNDARY: begin
                    state <= SECOND;
                    if (pop) begin
                        out_bit    <= head;
                        out_data   <= 1'b1;
                        second_bit <= ~head;
                        if (data_pairs != '1) begin
                            data_pairs <= data_pairs + CNT_W'(1);
                        end
                    end else begin
                        out_bit    <= fpol;
                        out_data   <= 1'b0;
                        second_bit <= fpol;
                        fpol       <= ~fpol;
                        if (fill_pairs != '1) begin
                            fill_pairs <= fill_pairs + CNT_W'(1);
                        end
                    end
                end
                SECOND: begin
                    state   <= BOUNDARY;
                    out_bit <= second_bit;
                end
                default: state <= BOUNDARY;
            endcase
            if (cnt_clr) begin
                data_pairs <= '0;
                fill_pairs <= '0;
            end
        end
    end
endmodule

// File: tb/tb_vn_pair_encoder.sv
// Directed bench for vn_pair_encoder: idle fillers, data pairs, FIFO full,
// concurrent push/pop, async reset mid-pair, counter saturation and clear.
module tb_vn_pair_encoder;
    logic        clk;
    logic        rstn;
    logic        tx_en;
    logic        cnt_clr;
    logic        out_bit;
    logic        out_phase;
    logic        out_data;
    logic [3:0]  level;
    logic [15:0] data_pairs;
    logic [15:0] fill_pairs;
    logic        out_bit4;
    logic        out_phase4;
    logic        out_data4;
    logic [3:0]  level4;
    logic [3:0]  data_pairs4;
    logic [3:0]  fill_pairs4;

    int checks = 0;
    int errors = 0;

    vn_pair_encoder_if bus ();
    vn_pair_encoder_if bus4 ();

    vn_pair_encoder #(.DEPTH(8), .CNT_W(16)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .bus        (bus),
        .tx_en      (tx_en),
        .cnt_clr    (cnt_clr),
        .out_bit    (out_bit),
        .out_phase  (out_phase),
        .out_data   (out_data),
        .level      (level),
        .data_pairs (data_pairs),
        .fill_pairs (fill_pairs)
    );

    vn_pair_encoder #(.DEPTH(8), .CNT_W(4)) dut4 (
        .clk        (clk),
        .rstn       (rstn),
        .bus        (bus4),
        .tx_en      (tx_en),
        .cnt_clr    (cnt_clr),
        .out_bit    (out_bit4),
        .out_phase  (out_phase4),
        .out_data   (out_data4),
        .level      (level4),
        .data_pairs (data_pairs4),
        .fill_pairs (fill_pairs4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input string tag, input logic v, input logic b,
                        input logic eb, input logic ed, input int el);
        bus.in_valid = v;
        bus.in_bit   = b;
        @(posedge clk);
        #1;
        chk({tag, ".bit"}, 32'(out_bit), 32'(eb));
        chk({tag, ".data"}, 32'(out_data), 32'(ed));
        chk({tag, ".level"}, 32'(level), 32'(el));
    endtask

    logic [7:0] idle;
    logic [9:0] t3;

    initial begin
        idle          = 8'b1100_1100;
        t3            = 10'b1101001011;
        rstn          = 1'b0;
        tx_en         = 1'b1;
        cnt_clr       = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_bit    = 1'b0;
        bus4.in_valid = 1'b0;
        bus4.in_bit   = 1'b0;

        #12;
        chk("rst.bit", 32'(out_bit), 0);
        chk("rst.phase", 32'(out_phase), 1);
        chk("rst.data", 32'(out_data), 0);
        chk("rst.level", 32'(level), 0);
        chk("rst.ready", 32'(bus.in_ready), 1);

        @(posedge clk);
        #1;
        rstn = 1'b1;

        // Idle stream: edges 1..8
        for (int i = 0; i < 8; i++) begin
            step("idle", 1'b0, 1'b0, idle[i], 1'b0, 0);
        end
        chk("idle.fill", 32'(fill_pairs), 4);
        chk("idle.datap", 32'(data_pairs), 0);

        // Push 1,0,1,1 on edges 9..12
        step("p9", 1'b1, 1'b1, 1'b0, 1'b0, 1);
        step("p10", 1'b1, 1'b0, 1'b0, 1'b0, 2);
        step("p11", 1'b1, 1'b1, 1'b1, 1'b1, 2);
        step("p12", 1'b1, 1'b1, 1'b0, 1'b1, 3);
        step("p13", 1'b0, 1'b0, 1'b0, 1'b1, 2);
        step("p14", 1'b0, 1'b0, 1'b1, 1'b1, 2);
        step("p15", 1'b0, 1'b0, 1'b1, 1'b1, 1);
        step("p16", 1'b0, 1'b0, 1'b0, 1'b1, 1);
        step("p17", 1'b0, 1'b0, 1'b1, 1'b1, 0);
        step("p18", 1'b0, 1'b0, 1'b0, 1'b1, 0);
        step("p19", 1'b0, 1'b0, 1'b1, 1'b0, 0);
        step("p20", 1'b0, 1'b0, 1'b1, 1'b0, 0);
        chk("p.datap", 32'(data_pairs), 4);
        chk("p.fill", 32'(fill_pairs), 6);

        // Fill FIFO with tx disabled: edges 21..30
        tx_en = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step("full", 1'b1, (i < 8) ? t3[i] : t3[8],
                 idle[i % 8], 1'b0, (i < 8) ? i + 1 : 8);
            if (i >= 7) begin
                chk("full.ready", 32'(bus.in_ready), 0);
            end
        end

        // Drain with tx enabled: edges 31..50
        tx_en = 1'b1;
        step("d31", 1'b1, t3[8], t3[0], 1'b1, 7);
        chk("d31.ready", 32'(bus.in_ready), 1);
        step("d32", 1'b1, t3[8], ~t3[0], 1'b1, 8);
        step("d33", 1'b1, t3[9], t3[1], 1'b1, 7);
        step("d34", 1'b1, t3[9], ~t3[1], 1'b1, 8);
        for (int i = 2; i < 10; i++) begin
            step("drain", 1'b0, 1'b0, t3[i], 1'b1, 9 - i);
            step("drain", 1'b0, 1'b0, ~t3[i], 1'b1, 9 - i);
        end
        chk("d.datap", 32'(data_pairs), 14);
        chk("d.fill", 32'(fill_pairs), 11);

        // Preload 0,1,1,0 with tx disabled: edges 51..54
        tx_en = 1'b0;
        step("l51", 1'b1, 1'b0, 1'b1, 1'b0, 1);
        step("l52", 1'b1, 1'b1, 1'b1, 1'b0, 2);
        step("l53", 1'b1, 1'b1, 1'b0, 1'b0, 3);
        step("l54", 1'b1, 1'b0, 1'b0, 1'b0, 4);

        // Concurrent push/pop from level 4: edges 55..63
        tx_en = 1'b1;
        step("l55", 1'b1, 1'b1, 1'b0, 1'b1, 4);
        step("l56", 1'b1, 1'b1, 1'b1, 1'b1, 5);
        step("l57", 1'b1, 1'b1, 1'b1, 1'b1, 5);
        step("l58", 1'b1, 1'b1, 1'b0, 1'b1, 6);
        step("l59", 1'b1, 1'b1, 1'b1, 1'b1, 6);
        step("l60", 1'b1, 1'b1, 1'b0, 1'b1, 7);
        step("l61", 1'b1, 1'b1, 1'b0, 1'b1, 7);
        step("l62", 1'b1, 1'b1, 1'b1, 1'b1, 8);
        step("l63", 1'b0, 1'b0, 1'b1, 1'b1, 7);
        chk("l.datap", 32'(data_pairs), 19);
        chk("l.fill", 32'(fill_pairs), 13);

        // Async reset during first half of a data pair
        rstn = 1'b0;
        #1;
        chk("ar.bit", 32'(out_bit), 0);
        chk("ar.phase", 32'(out_phase), 1);
        chk("ar.data", 32'(out_data), 0);
        chk("ar.level", 32'(level), 0);
        chk("ar.ready", 32'(bus.in_ready), 1);
        @(posedge clk);
        #1;
        rstn = 1'b1;

        // 20 idle pairs, then saturation and clear
        for (int i = 0; i < 40; i++) begin
            step("sat", 1'b0, 1'b0, idle[i % 8], 1'b0, 0);
            if (i == 0) begin
                chk("ar.fill", 32'(fill_pairs), 1);
                chk("ar.datap", 32'(data_pairs), 0);
            end
        end
        chk("sat.fill16", 32'(fill_pairs), 20);
        chk("sat.fill4", 32'(fill_pairs4), 15);
        chk("sat.datap", 32'(data_pairs), 0);

        cnt_clr = 1'b1;
        step("clr41", 1'b0, 1'b0, 1'b0, 1'b0, 0);
        chk("clr.fill16", 32'(fill_pairs), 0);
        chk("clr.fill4", 32'(fill_pairs4), 0);
        cnt_clr = 1'b0;
        step("clr42", 1'b0, 1'b0, 1'b0, 1'b0, 0);
        step("clr43", 1'b0, 1'b0, 1'b1, 1'b0, 0);
        chk("clr.fill16b", 32'(fill_pairs), 1);
        chk("clr.fill4b", 32'(fill_pairs4), 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
